// File: rtl/gates_pkg.sv
// rtl/gates_pkg.sv - shared operator encodings and tree-sizing helpers for the gates library
package gates_pkg;

    localparam int OP_OR  = 0;
    localparam int OP_AND = 1;
    localparam int OP_XOR = 2;

    // Number of register levels needed to reduce n inputs with the given fan-in (minimum 1).
    function automatic int reduce_levels(input int n, input int fanin);
        int l;
        int p;
        l = 1;
        p = fanin;
        for (int i = 0; i < 8; i++) begin
            if (p < n) begin
                p = p * fanin;
                l = l + 1;
            end
        end
        return l;
    endfunction

    function automatic int fanin_pow(input int fanin, input int e);
        int p;
        p = 1;
        for (int i = 0; i < 8; i++) begin
            if (i < e) begin
                p = p * fanin;
            end
        end
        return p;
    endfunction

    // Bit offset of tree level k inside the flat tree bus; level 0 is the padded input
    // of width fanin^levels, each following level is fanin times narrower.
    function automatic int level_offset(input int fanin, input int levels, input int k);
        int off;
        int p;
        off = 0;
        p   = fanin_pow(fanin, levels);
        for (int i = 0; i < 8; i++) begin
            if (i < k) begin
                off = off + p;
                p   = p / fanin;
            end
        end
        return off;
    endfunction

    // Pad bit that leaves the reduction unchanged.
    function automatic logic op_identity(input int op);
        return (op == OP_AND);
    endfunction

endpackage

// File: rtl/reduce_gate_stage.sv
// rtl/reduce_gate_stage.sv - one registered level of the reduction tree with its valid bit
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset, clears data and valid
//   valid_in  valid bit of the previous level
//   din       previous level data, IN_WIDTH bits (a multiple of STAGE_FANIN)
//   dout      reduced data, IN_WIDTH/STAGE_FANIN bits
//   valid_out valid bit of this level
module reduce_gate_stage
    import gates_pkg::*;
#(
    parameter int IN_WIDTH      = 4,
    parameter int STAGE_FANIN   = 4,
    parameter int OPERATION     = OP_OR,
    // Final level holds its value between valid samples; inner levels load every cycle.
    parameter bit LOAD_ON_VALID = 1'b0,
    localparam int OUT_WIDTH    = IN_WIDTH / STAGE_FANIN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [IN_WIDTH-1:0]  din,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 valid_out
);

    logic [OUT_WIDTH-1:0] nxt;

    always_comb begin
        nxt = '0;
        for (int g = 0; g < OUT_WIDTH; g++) begin
            case (OPERATION)
                OP_AND:  nxt[g] = &din[g*STAGE_FANIN +: STAGE_FANIN];
                OP_XOR:  nxt[g] = ^din[g*STAGE_FANIN +: STAGE_FANIN];
                default: nxt[g] = |din[g*STAGE_FANIN +: STAGE_FANIN];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout      <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= valid_in;
            if (!LOAD_ON_VALID || valid_in) begin
                dout <= nxt;
            end
        end
    end

endmodule

// File: rtl/reduce_gate_pipe.sv
// rtl/reduce_gate_pipe.sv - pipelined N-input OR/AND/XOR reduction gate with bubble mask
//
// Optional feature macro: REDUCE_GATE_PIPE_STICKY_EN (adds ClearSticky/Sticky).
//
// Ports:
//   Clock        rising-edge clock
//   Reset        synchronous active-high reset, clears all state
//   Enable       sample strobe, Inputs captured when high
//   Inputs       NR_OF_INPUTS reduction operands
//   Result       last valid reduction result (registered)
//   ResultValid  one-cycle pulse when Result is updated
//   ClearSticky  clears Sticky (sticky build only)
//   Sticky       set once any valid Result is 1 (sticky build only)
module reduce_gate_pipe
    import gates_pkg::*;
#(
    parameter int                      NR_OF_INPUTS = 18,
    parameter logic [NR_OF_INPUTS-1:0] BUBBLES_MASK = '0,
    parameter int                      OPERATION    = OP_OR,
    parameter int                      STAGE_FANIN  = 4
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Enable,
    input  logic [NR_OF_INPUTS-1:0] Inputs,
    output logic                    Result,
    output logic                    ResultValid
`ifdef REDUCE_GATE_PIPE_STICKY_EN
    ,
    input  logic                    ClearSticky,
    output logic                    Sticky
`endif
);

    localparam int   L       = reduce_levels(NR_OF_INPUTS, STAGE_FANIN);
    localparam int   PAD_W   = fanin_pow(STAGE_FANIN, L);
    localparam int   TREE_W  = level_offset(STAGE_FANIN, L, L) + 1;
    localparam logic PAD_BIT = op_identity(OPERATION);

    if (OPERATION < OP_OR || OPERATION > OP_XOR) begin : g_bad_operation
        $error("reduce_gate_pipe: OPERATION must be 0 (OR), 1 (AND) or 2 (XOR)");
    end
    if (NR_OF_INPUTS < 2 || NR_OF_INPUTS > 64) begin : g_bad_width
        $error("reduce_gate_pipe: NR_OF_INPUTS must be in 2..64");
    end
    if (STAGE_FANIN < 2 || STAGE_FANIN > 8) begin : g_bad_fanin
        $error("reduce_gate_pipe: STAGE_FANIN must be in 2..8");
    end

    // All tree levels packed into one bus, level 0 (padded bubbled inputs) at the bottom,
    // the single-bit final level at the top.
    logic [TREE_W-1:0] tree;
    logic [L:0]        vld;
    logic [PAD_W-1:0]  level0;

    always_comb begin
        level0                   = {PAD_W{PAD_BIT}};
        level0[NR_OF_INPUTS-1:0] = Inputs ^ BUBBLES_MASK;
    end

    assign tree[PAD_W-1:0] = level0;
    assign vld[0]          = Enable;

    for (genvar k = 1; k <= L; k++) begin : g_lvl
        localparam int IW = fanin_pow(STAGE_FANIN, L - k + 1);
        localparam int OW = IW / STAGE_FANIN;
        localparam int IO = level_offset(STAGE_FANIN, L, k - 1);
        localparam int OO = level_offset(STAGE_FANIN, L, k);

        reduce_gate_stage #(
            .IN_WIDTH      (IW),
            .STAGE_FANIN   (STAGE_FANIN),
            .OPERATION     (OPERATION),
            .LOAD_ON_VALID (k == L)
        ) u_stage (
            .clk       (Clock),
            .rst       (Reset),
            .valid_in  (vld[k-1]),
            .din       (tree[IO +: IW]),
            .dout      (tree[OO +: OW]),
            .valid_out (vld[k])
        );
    end

    // The last level register is the Result register: it only loads on a valid sample.
    assign Result      = tree[TREE_W-1];
    assign ResultValid = vld[L];

`ifdef REDUCE_GATE_PIPE_STICKY_EN
    // Set term is ORed after the clear so a result arriving with ClearSticky is kept.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Sticky <= 1'b0;
        end else begin
            Sticky <= (Sticky & ~ClearSticky) | (ResultValid & Result);
        end
    end
`endif

endmodule

// File: tb/tb_reduce_gate_pipe.sv
// tb/tb_reduce_gate_pipe.sv - directed self-checking bench for reduce_gate_pipe
module tb_reduce_gate_pipe;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;

    logic        en_or = 1'b0,  en_and = 1'b0, en_xor = 1'b0, en_sm = 1'b0;
    logic [17:0] in_or = '0,    in_and = '0,   in_xor = '0;
    logic [2:0]  in_sm = '0;
    logic        res_or, res_and, res_xor, res_sm;
    logic        rv_or,  rv_and,  rv_xor,  rv_sm;
`ifdef REDUCE_GATE_PIPE_STICKY_EN
    logic        clr_or = 1'b0, clr_and = 1'b0, clr_xor = 1'b0, clr_sm = 1'b0;
    logic        st_or, st_and, st_xor, st_sm;
`endif

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    reduce_gate_pipe #(.NR_OF_INPUTS(18), .BUBBLES_MASK(18'h0), .OPERATION(0), .STAGE_FANIN(4)) u_or (
        .Clock(Clock), .Reset(Reset), .Enable(en_or), .Inputs(in_or),
        .Result(res_or), .ResultValid(rv_or)
`ifdef REDUCE_GATE_PIPE_STICKY_EN
        , .ClearSticky(clr_or), .Sticky(st_or)
`endif
    );

    reduce_gate_pipe #(.NR_OF_INPUTS(18), .BUBBLES_MASK(18'h00001), .OPERATION(1), .STAGE_FANIN(4)) u_and (
        .Clock(Clock), .Reset(Reset), .Enable(en_and), .Inputs(in_and),
        .Result(res_and), .ResultValid(rv_and)
`ifdef REDUCE_GATE_PIPE_STICKY_EN
        , .ClearSticky(clr_and), .Sticky(st_and)
`endif
    );

    reduce_gate_pipe #(.NR_OF_INPUTS(18), .BUBBLES_MASK(18'h0), .OPERATION(2), .STAGE_FANIN(4)) u_xor (
        .Clock(Clock), .Reset(Reset), .Enable(en_xor), .Inputs(in_xor),
        .Result(res_xor), .ResultValid(rv_xor)
`ifdef REDUCE_GATE_PIPE_STICKY_EN
        , .ClearSticky(clr_xor), .Sticky(st_xor)
`endif
    );

    reduce_gate_pipe #(.NR_OF_INPUTS(3), .BUBBLES_MASK(3'b000), .OPERATION(1), .STAGE_FANIN(4)) u_sm (
        .Clock(Clock), .Reset(Reset), .Enable(en_sm), .Inputs(in_sm),
        .Result(res_sm), .ResultValid(rv_sm)
`ifdef REDUCE_GATE_PIPE_STICKY_EN
        , .ClearSticky(clr_sm), .Sticky(st_sm)
`endif
    );

    task automatic step;
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        step();
        step();
        checks++; if (rv_or  !== 1'b0) begin errors++; $display("FAIL reset_rv_or got %b want 0", rv_or); end
        checks++; if (res_or !== 1'b0) begin errors++; $display("FAIL reset_res_or got %b want 0", res_or); end
        checks++; if (rv_and !== 1'b0) begin errors++; $display("FAIL reset_rv_and got %b want 0", rv_and); end
        checks++; if (res_and !== 1'b0) begin errors++; $display("FAIL reset_res_and got %b want 0", res_and); end
        checks++; if (rv_xor !== 1'b0) begin errors++; $display("FAIL reset_rv_xor got %b want 0", rv_xor); end
        checks++; if (res_xor !== 1'b0) begin errors++; $display("FAIL reset_res_xor got %b want 0", res_xor); end
        checks++; if (rv_sm !== 1'b0) begin errors++; $display("FAIL reset_rv_sm got %b want 0", rv_sm); end
        checks++; if (res_sm !== 1'b0) begin errors++; $display("FAIL reset_res_sm got %b want 0", res_sm); end
`ifdef REDUCE_GATE_PIPE_STICKY_EN
        checks++; if (st_or !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b want 0", st_or); end
`endif
        Reset = 1'b0;
        step();
    endtask

    task automatic test_or;
        logic [17:0] vec [2];
        logic        exp [2];
        int          n;
        vec[0] = 18'h00000; exp[0] = 1'b0;
        vec[1] = 18'h00020; exp[1] = 1'b1;
        for (int t = 0; t < 2; t++) begin
            in_or = vec[t];
            en_or = 1'b1;
            step();
            en_or = 1'b0;
            n = 1;
            while (!rv_or && n < 10) begin
                step();
                n++;
            end
            checks++; if (n !== 3) begin errors++; $display("FAIL or_latency[%0d] got %0d want 3", t, n); end
            checks++; if (res_or !== exp[t]) begin errors++; $display("FAIL or_result[%0d] got %b want %b", t, res_or, exp[t]); end
            step();
            checks++; if (rv_or !== 1'b0) begin errors++; $display("FAIL or_single_pulse[%0d] got %b want 0", t, rv_or); end
            checks++; if (res_or !== exp[t]) begin errors++; $display("FAIL or_hold[%0d] got %b want %b", t, res_or, exp[t]); end
        end
    endtask

    task automatic test_and_bubble;
        logic [17:0] vec [2];
        logic        exp [2];
        int          n;
        vec[0] = 18'h3FFFE; exp[0] = 1'b1;
        vec[1] = 18'h3FFFF; exp[1] = 1'b0;
        for (int t = 0; t < 2; t++) begin
            in_and = vec[t];
            en_and = 1'b1;
            step();
            en_and = 1'b0;
            n = 1;
            while (!rv_and && n < 10) begin
                step();
                n++;
            end
            checks++; if (n !== 3) begin errors++; $display("FAIL and_latency[%0d] got %0d want 3", t, n); end
            checks++; if (res_and !== exp[t]) begin errors++; $display("FAIL and_result[%0d] got %b want %b", t, res_and, exp[t]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [17:0] vec [4];
        logic        exp [4];
        logic        want_rv;
        vec[0] = 18'h00001; exp[0] = 1'b1;
        vec[1] = 18'h00003; exp[1] = 1'b0;
        vec[2] = 18'h3FFFF; exp[2] = 1'b0;
        vec[3] = 18'h00000; exp[3] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin
                en_xor = 1'b1;
                in_xor = vec[c];
            end else begin
                en_xor = 1'b0;
            end
            step();
            want_rv = (c >= 2 && c <= 5);
            checks++; if (rv_xor !== want_rv) begin errors++; $display("FAIL xor_valid[c%0d] got %b want %b", c, rv_xor, want_rv); end
            if (want_rv) begin
                checks++; if (res_xor !== exp[c-2]) begin errors++; $display("FAIL xor_result[c%0d] got %b want %b", c, res_xor, exp[c-2]); end
            end
        end
    endtask

`ifdef REDUCE_GATE_PIPE_STICKY_EN
    task automatic test_sticky;
        int n;
        clr_or = 1'b1;
        step();
        clr_or = 1'b0;
        checks++; if (st_or !== 1'b0) begin errors++; $display("FAIL sticky_initial_clear got %b want 0", st_or); end
        for (int t = 0; t < 2; t++) begin
            in_or = 18'h00004;
            en_or = 1'b1;
            step();
            en_or = 1'b0;
            n = 1;
            while (!rv_or && n < 10) begin
                step();
                n++;
            end
            checks++; if (rv_or !== 1'b1) begin errors++; $display("FAIL sticky_wait[%0d] got %b want 1", t, rv_or); end
            // Second pass clears in the very cycle the valid 1 result is presented.
            clr_or = (t == 1);
            step();
            clr_or = 1'b0;
            checks++; if (st_or !== 1'b1) begin errors++; $display("FAIL sticky_set[%0d] got %b want 1", t, st_or); end
        end
        clr_or = 1'b1;
        step();
        clr_or = 1'b0;
        checks++; if (st_or !== 1'b0) begin errors++; $display("FAIL sticky_clear got %b want 0", st_or); end
    endtask
`endif

    task automatic test_reset_mid;
        in_or = 18'h00001;
        en_or = 1'b1;
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        en_or = 1'b0;
        checks++; if (res_or !== 1'b0) begin errors++; $display("FAIL mid_reset_result got %b want 0", res_or); end
        for (int c = 0; c < 6; c++) begin
            step();
            checks++; if (rv_or !== 1'b0) begin errors++; $display("FAIL mid_reset_valid[c%0d] got %b want 0", c, rv_or); end
            checks++; if (res_or !== 1'b0) begin errors++; $display("FAIL mid_reset_hold[c%0d] got %b want 0", c, res_or); end
        end
    endtask

    task automatic test_small;
        logic [2:0] vec [2];
        logic       exp [2];
        vec[0] = 3'b111; exp[0] = 1'b1;
        vec[1] = 3'b011; exp[1] = 1'b0;
        for (int t = 0; t < 2; t++) begin
            in_sm = vec[t];
            en_sm = 1'b1;
            step();
            en_sm = 1'b0;
            checks++; if (rv_sm !== 1'b1) begin errors++; $display("FAIL small_latency[%0d] got %b want 1", t, rv_sm); end
            checks++; if (res_sm !== exp[t]) begin errors++; $display("FAIL small_result[%0d] got %b want %b", t, res_sm, exp[t]); end
            step();
            checks++; if (rv_sm !== 1'b0) begin errors++; $display("FAIL small_pulse[%0d] got %b want 0", t, rv_sm); end
        end
    endtask

    initial begin
        test_reset();
        test_or();
        test_and_bubble();
        test_back_to_back();
`ifdef REDUCE_GATE_PIPE_STICKY_EN
        test_sticky();
        in_or = 18'h00020;
        en_or = 1'b1;
        step();
        en_or = 1'b0;
        step();
        step();
        step();
`endif
        test_reset_mid();
        test_small();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
